// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe -- registered EXE-stage ALU with a valid/ready handshake on both
// sides. A single-cycle op is accepted at one edge and its result and status
// {z,c,n,v} are valid right after that edge. They are held until the consumer
// takes them.
//
// Optional feature macro: ALU_PIPE_MUL_EN
//   defined     : cmd 13 (MUL) runs a shift-add multiply. It retires MUL_BPC
//                 multiplier bits per cycle, so latency is WIDTH/MUL_BPC + 1
//                 edges from accept.
//   not defined : cmd 13 is treated like the reserved codes (result 0,
//                 sr 4'b1000, latency 1).
//
// Parameters
//   WIDTH     operand/result width (>= 8)
//   MUL_BPC   multiplier bits retired per cycle; must divide WIDTH
//
// Ports
//   clk        clock; all state changes on posedge
//   rst_n      synchronous reset, active low
//   in_valid   operands/command valid
//   in_ready   block can accept an op this cycle
//   val1       operand A (Rn)
//   val2       operand B (shifter output)
//   cin        carry flag from the status register
//   exe_cmd    operation code
//   out_valid  result/sr valid
//   out_ready  consumer takes the result this cycle
//   result     registered result
//   sr         registered status {z,c,n,v}
// -----------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH   = 32,
    parameter int MUL_BPC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic             cin,
    input  logic [3:0]       exe_cmd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       sr
);

    typedef enum logic [3:0] {
        CMD_MOV = 4'd0,  CMD_MVN = 4'd1,  CMD_ADD = 4'd2,  CMD_ADC = 4'd3,
        CMD_SUB = 4'd4,  CMD_SBC = 4'd5,  CMD_AND = 4'd6,  CMD_ORR = 4'd7,
        CMD_EOR = 4'd8,  CMD_CMP = 4'd9,  CMD_TST = 4'd10, CMD_LDR = 4'd11,
        CMD_STR = 4'd12, CMD_MUL = 4'd13
    } cmd_e;

    if (WIDTH < 8 || MUL_BPC < 1 || (WIDTH % MUL_BPC) != 0) begin : g_param_check
        $error("alu_pipe: WIDTH must be >= 8 and MUL_BPC must divide WIDTH");
    end

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       sr_q;
    logic             accept;
    logic             handoff;

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign sr        = sr_q;
    assign accept    = in_valid && in_ready;
    assign handoff   = out_valid_q && out_ready;

    // ---------------------------------------------------------------- ALU core
    // Subtraction is folded into the adder as a + ~b + carry_in. The adder's
    // carry out is therefore NOT borrow, which is the ARM convention.
    logic [WIDTH-1:0] b_eff;
    logic             carry_in;
    logic             is_arith;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res_d;
    logic             alu_c;
    logic             alu_v;
    logic [3:0]       alu_sr_d;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        b_eff     = val2;
        carry_in  = 1'b0;
        is_arith  = 1'b0;
        alu_res_d = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        case (exe_cmd)
            CMD_MOV:          alu_res_d = val2;
            CMD_MVN:          alu_res_d = ~val2;
            CMD_ADD:          is_arith  = 1'b1;
            CMD_ADC: begin
                is_arith = 1'b1;
                carry_in = cin;
            end
            CMD_SUB, CMD_CMP: begin
                is_arith = 1'b1;
                b_eff    = ~val2;
                carry_in = 1'b1;
            end
            CMD_SBC: begin
                is_arith = 1'b1;
                b_eff    = ~val2;
                carry_in = cin;
            end
            CMD_AND, CMD_TST: alu_res_d = val1 & val2;
            CMD_ORR:          alu_res_d = val1 | val2;
            CMD_EOR:          alu_res_d = val1 ^ val2;
            CMD_LDR, CMD_STR: alu_res_d = val1 + val2;
            default:          alu_res_d = '0;  // reserved (and MUL when not built)
        endcase
        sum = {1'b0, val1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
        if (is_arith) begin
            alu_res_d = sum[WIDTH-1:0];
            alu_c     = sum[WIDTH];
            // Overflow: both effective operands share a sign that the result lacks.
            alu_v     = (val1[WIDTH-1] == b_eff[WIDTH-1]) &&
                        (alu_res_d[WIDTH-1] != val1[WIDTH-1]);
        end
        alu_sr_d = {alu_res_d == '0, alu_c, alu_res_d[WIDTH-1], alu_v};
    end

`ifdef ALU_PIPE_MUL_EN
    // ---------------------------------------------------------- multi-cycle MUL
    localparam int MUL_STEPS = WIDTH / MUL_BPC;
    localparam int CNT_W     = $clog2(MUL_STEPS + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] mcand_q;   // multiplicand, pre-shifted by bits already retired
    logic [WIDTH-1:0] mplier_q;  // remaining multiplier bits, consumed from the LSB
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [CNT_W-1:0] cnt_q;

    assign in_ready = rst_n && (state_q == S_IDLE) && (!out_valid_q || out_ready);

    always_comb begin
        acc_d = acc_q;
        for (int j = 0; j < MUL_BPC; j++) begin
            if (mplier_q[j]) acc_d = acc_d + (mcand_q << j);
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            sr_q        <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept && exe_cmd == CMD_MUL) begin
                        state_q     <= S_MUL;
                        out_valid_q <= 1'b0;  // any old result is handed off this edge
                        mcand_q     <= val1;
                        mplier_q    <= val2;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                    end else if (accept) begin
                        out_valid_q <= 1'b1;
                        result_q    <= alu_res_d;
                        sr_q        <= alu_sr_d;
                    end else if (handoff) begin
                        out_valid_q <= 1'b0;
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << MUL_BPC;
                    mplier_q <= mplier_q >> MUL_BPC;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(MUL_STEPS - 1)) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= acc_d;
                        sr_q        <= {acc_d == '0, 1'b0, acc_d[WIDTH-1], 1'b0};
                    end
                end
                S_DONE: begin
                    if (handoff) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
`else
    assign in_ready = rst_n && (!out_valid_q || out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            sr_q        <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            result_q    <= alu_res_d;
            sr_q        <= alu_sr_d;
        end else if (handoff) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe -- self-checking bench for alu_pipe (WIDTH=32, MUL_BPC=1).
// Expected values come from a behavioural model that uses plain 64-bit
// arithmetic. Inputs are driven on the falling edge, and outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] val1;
    logic [31:0] val2;
    logic        cin;
    logic [3:0]  exe_cmd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  sr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] got[$];

    alu_pipe #(.WIDTH(32), .MUL_BPC(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .val1      (val1),
        .val2      (val2),
        .cin       (cin),
        .exe_cmd   (exe_cmd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .sr        (sr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: returns {z,c,n,v, result} from the architectural rules.
    function automatic logic [35:0] model(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
        longint unsigned ua, ub, u, nb;
        longint          sa, sb, s;
        logic [31:0]     r;
        logic            cf, vf;
        ua = a;  ub = b;  sa = $signed(a);  sb = $signed(b);
        nb = c ? 64'd0 : 64'd1;  // borrow for SBC
        r = '0;  cf = 1'b0;  vf = 1'b0;
        case (cmd)
            4'd0: r = b;
            4'd1: r = ~b;
            4'd2, 4'd3: begin
                u  = ua + ub + ((cmd == 4'd3) ? longint'(c) : 64'd0);
                s  = sa + sb + ((cmd == 4'd3) ? longint'(c) : 64'd0);
                r  = u[31:0];
                cf = u[32];
                vf = (s != longint'($signed(r)));
            end
            4'd4, 4'd9: begin
                r  = a - b;
                cf = (ua >= ub);
                s  = sa - sb;
                vf = (s != longint'($signed(r)));
            end
            4'd5: begin
                r  = a - b - nb[31:0];
                cf = (ua >= ub + nb);
                s  = sa - sb - longint'(nb);
                vf = (s != longint'($signed(r)));
            end
            4'd6, 4'd10: r = a & b;
            4'd7:        r = a | b;
            4'd8:        r = a ^ b;
            4'd11, 4'd12: r = a + b;
`ifdef ALU_PIPE_MUL_EN
            4'd13:       r = a * b;
`endif
            default:     r = '0;  // reserved: z=1, everything else 0
        endcase
        return {r == 32'd0, cf, r[31], vf, r};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issues one op with out_ready held high. Checks the result, status and
    // latency, and counts the cycles in_ready stays low after the accept.
    task automatic run_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input string tag);
        logic [35:0] exp;
        int          lat;
        int          low_cnt;
        int          exp_lat;
        exp     = model(cmd, a, b, c);
        exp_lat = 1;
`ifdef ALU_PIPE_MUL_EN
        if (cmd == 4'd13) exp_lat = 33;
`endif
        @(negedge clk);
        in_valid = 1'b1;  exe_cmd = cmd;  val1 = a;  val2 = b;  cin = c;  out_ready = 1'b1;
        #1;
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        low_cnt  = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) low_cnt++;
            @(negedge clk);
            lat++;
        end
        if (!in_ready) low_cnt++;
        check({tag, ".latency"},   64'(lat),       64'(exp_lat));
        check({tag, ".ready_low"}, 64'(low_cnt),   64'(exp_lat == 1 ? 0 : exp_lat));
        check({tag, ".result"},    64'(result),    64'(exp[31:0]));
        check({tag, ".sr"},        64'(sr),        64'(exp[35:32]));
    endtask

    initial begin
        // ------------------------------------------------------------ reset
        rst_n = 1'b0;  in_valid = 1'b0;  out_ready = 1'b0;
        val1 = '0;  val2 = '0;  cin = 1'b0;  exe_cmd = '0;
        repeat (3) @(negedge clk);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.result",    64'(result),    64'd0);
        check("rst.sr",        64'(sr),        64'd0);
        check("rst.in_ready",  64'(in_ready),  64'd0);
        rst_n = 1'b1;
        #1;
        check("rst.release_ready", 64'(in_ready), 64'd1);

        // --------------------------------------------- directed arithmetic
        run_op(4'd2, 32'h7FFF_FFFF, 32'h1, 1'b0, "add_ovf");
        check("add_ovf.lit", 64'({sr, result}), 64'({4'b0011, 32'h8000_0000}));
        run_op(4'd4, 32'd5, 32'd5, 1'b0, "sub_eq");
        check("sub_eq.lit", 64'({sr, result}), 64'({4'b1100, 32'h0}));
        run_op(4'd4, 32'd3, 32'd5, 1'b0, "sub_neg");
        check("sub_neg.lit", 64'({sr, result}), 64'({4'b0010, 32'hFFFF_FFFE}));
        run_op(4'd5, 32'd5, 32'd5, 1'b0, "sbc_c0");
        check("sbc_c0.lit", 64'({sr[2], result}), 64'({1'b0, 32'hFFFF_FFFF}));
        run_op(4'd3, 32'hFFFF_FFFF, 32'h0, 1'b1, "adc_wrap");
        run_op(4'd9, 32'h8000_0000, 32'h1, 1'b0, "cmp_ovf");
        run_op(4'd14, 32'h1234, 32'h5678, 1'b1, "rsv14");
        check("rsv14.lit", 64'({sr, result}), 64'({4'b1000, 32'h0}));
        run_op(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "rsv15");

        // ------------------------------------------------------------- MUL
        run_op(4'd13, 32'd7, 32'd6, 1'b0, "mul_7x6");
`ifdef ALU_PIPE_MUL_EN
        check("mul_7x6.lit", 64'({sr, result}), 64'({4'b0000, 32'd42}));
`else
        check("mul_7x6.lit", 64'({sr, result}), 64'({4'b1000, 32'd0}));
`endif
        run_op(4'd13, 32'h0001_0000, 32'h0001_0000, 1'b0, "mul_wrap");
        check("mul_wrap.lit", 64'({sr, result}), 64'({4'b1000, 32'd0}));

        // ------------------------------------- back-to-back MOV with stall
        got.delete();
        @(negedge clk);
        in_valid = 1'b1;  exe_cmd = 4'd0;  val1 = '0;  val2 = 32'd1;  out_ready = 1'b1;
        #1;
        check("b2b.c1_ready", 64'(in_ready), 64'd1);
        if (out_valid && out_ready) got.push_back(result);
        @(negedge clk);
        val2 = 32'd2;  out_ready = 1'b0;
        #1;
        check("b2b.c2_ready",  64'(in_ready), 64'd0);
        check("b2b.c2_result", 64'(result),   64'd1);
        if (out_valid && out_ready) got.push_back(result);
        @(negedge clk);
        #1;
        check("b2b.c3_ready",  64'(in_ready),  64'd0);
        check("b2b.c3_valid",  64'(out_valid), 64'd1);
        check("b2b.c3_result", 64'(result),    64'd1);
        if (out_valid && out_ready) got.push_back(result);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("b2b.c4_ready", 64'(in_ready), 64'd1);
        if (out_valid && out_ready) got.push_back(result);
        @(negedge clk);
        val2 = 32'd3;
        if (out_valid && out_ready) got.push_back(result);
        @(negedge clk);
        in_valid = 1'b0;
        if (out_valid && out_ready) got.push_back(result);
        @(negedge clk);
        check("b2b.drained", 64'(out_valid), 64'd0);
        check("b2b.count",   64'(got.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("b2b.order%0d", i),
                  64'((i < got.size()) ? got[i] : 32'hDEAD_BEEF), 64'(i + 1));

        // ---------------------------------------------------- mid-op reset
`ifdef ALU_PIPE_MUL_EN
        @(negedge clk);
        in_valid = 1'b1;  exe_cmd = 4'd13;  val1 = 32'd7;  val2 = 32'd6;  out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mul.out_valid", 64'(out_valid), 64'd0);
        check("rst_mul.result",    64'(result),    64'd0);
        check("rst_mul.sr",        64'(sr),        64'd0);
        check("rst_mul.in_ready",  64'(in_ready),  64'd0);
        rst_n = 1'b1;
        begin
            int seen = 0;
            repeat (40) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check("rst_mul.abandoned", 64'(seen), 64'd0);
        end
`else
        @(negedge clk);
        in_valid = 1'b1;  exe_cmd = 4'd0;  val2 = 32'h55;  out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_held.pre_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_held.out_valid", 64'(out_valid), 64'd0);
        check("rst_held.result",    64'(result),    64'd0);
        check("rst_held.sr",        64'(sr),        64'd0);
        check("rst_held.in_ready",  64'(in_ready),  64'd0);
        rst_n = 1'b1;
`endif
        run_op(4'd2, 32'd1, 32'd1, 1'b0, "post_rst_add");
        check("post_rst_add.lit", 64'(result), 64'd2);

        // ---------------------------------------------------- random sweep
        for (int k = 0; k < 60; k++) begin
            logic [3:0] rc;
            rc = 4'($urandom_range(0, 15));
            run_op(rc, pick(), pick(), 1'($urandom_range(0, 1)), $sformatf("rnd%0d_cmd%0d", k, rc));
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
